// File: rtl/verificador_tabuleiro_if.sv
// Board-checker bus: start/result handshake with the control unit
// plus the synchronous-read port of the board RAM.
interface verificador_tabuleiro_if #(
  parameter int MACRO_W = 4,
  parameter int CELL_W  = 2
);
  logic               iniciar;
  logic [MACRO_W-1:0] tabuleiro;
  logic [CELL_W-1:0]  dado;
  logic [MACRO_W-1:0] addr_macro;
  logic [3:0]         addr_celula;
  logic               le_ram;
  logic               ocupado;
  logic               pronto;
  logic               vitoria;
  logic [CELL_W-1:0]  vencedor;
  logic               empate;
  logic               cheio;
  logic               erro;
  logic [2:0]         db_estado;

  modport master (
    output iniciar, tabuleiro, dado,
    input  addr_macro, addr_celula, le_ram, ocupado, pronto,
    input  vitoria, vencedor, empate, cheio, erro, db_estado
  );

  modport slave (
    input  iniciar, tabuleiro, dado,
    output addr_macro, addr_celula, le_ram, ocupado, pronto,
    output vitoria, vencedor, empate, cheio, erro, db_estado
  );
endinterface

// File: rtl/verificador_tabuleiro.sv
// Scans one 3x3 board from the board RAM and reports
// winner / draw / full / error to the game control unit.
module verificador_tabuleiro #(
  parameter int MACRO_W = 4,
  parameter int CELL_W  = 2
) (
  input logic clock,
  input logic reset,
  verificador_tabuleiro_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LEITURA = 3'd1,
    ESPERA  = 3'd2,
    AVALIA  = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [CELL_W-1:0] C_X   = CELL_W'(1);
  localparam logic [CELL_W-1:0] C_O   = CELL_W'(2);
  localparam logic [CELL_W-1:0] C_INV = '1;

  estado_t            state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         idxd_q, idxd_d;
  logic               cap_q, cap_d;
  logic [MACRO_W-1:0] mac_q, mac_d;
  logic [CELL_W-1:0]  cell_q [9];
  logic [CELL_W-1:0]  cell_d [9];
  logic               vit_q, vit_d;
  logic [CELL_W-1:0]  ven_q, ven_d;
  logic               emp_q, emp_d;
  logic               che_q, che_d;
  logic               err_q, err_d;
  logic               le_q, le_d;
  logic               ocu_q, ocu_d;
  logic               pro_q, pro_d;

  logic [8:0] mx, mo, mi;
  logic       xw, ow;

  function automatic logic linha(input logic [8:0] m);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) |
           (m[6] & m[7] & m[8]) | (m[0] & m[3] & m[6]) |
           (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      mx[i] = (cell_q[i] == C_X);
      mo[i] = (cell_q[i] == C_O);
      mi[i] = (cell_q[i] == C_INV);
    end
    xw = linha(mx);
    ow = linha(mo);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mac_d   = mac_q;
    cell_d  = cell_q;
    vit_d   = vit_q;
    ven_d   = ven_q;
    emp_d   = emp_q;
    che_d   = che_q;
    err_d   = err_q;
    // RAM data lags the address by one cycle
    cap_d   = (state_q == LEITURA);
    idxd_d  = idx_q;
    if (cap_q) cell_d[idxd_q] = bus.dado;
    case (state_q)
      OCIOSO: begin
        if (bus.iniciar) begin
          mac_d   = bus.tabuleiro;
          idx_d   = 4'd0;
          state_d = LEITURA;
        end
      end
      LEITURA: begin
        if (idx_q == 4'd8) begin
          idx_d   = 4'd0;
          state_d = ESPERA;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ESPERA: state_d = AVALIA;
      AVALIA: begin
        vit_d   = xw | ow;
        ven_d   = xw ? C_X : (ow ? C_O : '0);
        che_d   = &(mx | mo);
        emp_d   = !(xw | ow) && (&(mx | mo));
        err_d   = (|mi) | (xw & ow);
        state_d = FIM;
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
    le_d  = (state_d == LEITURA);
    ocu_d = (state_d != OCIOSO);
    pro_d = (state_d == FIM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= OCIOSO;
      idx_q   <= '0;
      idxd_q  <= '0;
      cap_q   <= 1'b0;
      mac_q   <= '0;
      cell_q  <= '{default: '0};
      vit_q   <= 1'b0;
      ven_q   <= '0;
      emp_q   <= 1'b0;
      che_q   <= 1'b0;
      err_q   <= 1'b0;
      le_q    <= 1'b0;
      ocu_q   <= 1'b0;
      pro_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      idxd_q  <= idxd_d;
      cap_q   <= cap_d;
      mac_q   <= mac_d;
      cell_q  <= cell_d;
      vit_q   <= vit_d;
      ven_q   <= ven_d;
      emp_q   <= emp_d;
      che_q   <= che_d;
      err_q   <= err_d;
      le_q    <= le_d;
      ocu_q   <= ocu_d;
      pro_q   <= pro_d;
    end
  end

  assign bus.addr_macro  = mac_q;
  assign bus.addr_celula = idx_q;
  assign bus.le_ram      = le_q;
  assign bus.ocupado     = ocu_q;
  assign bus.pronto      = pro_q;
  assign bus.vitoria     = vit_q;
  assign bus.vencedor    = ven_q;
  assign bus.empate      = emp_q;
  assign bus.cheio       = che_q;
  assign bus.erro        = err_q;
  assign bus.db_estado   = state_q;

endmodule

// File: tb/tb_verificador_tabuleiro.sv
// Directed scoreboard bench for verificador_tabuleiro with a
// synchronous-read board RAM model.
module tb_verificador_tabuleiro;

  typedef struct packed {
    logic       vit;
    logic [1:0] ven;
    logic       emp;
    logic       che;
    logic       err;
  } exp_t;

  logic clock;
  logic reset;
  logic [1:0] mem [16][9];
  exp_t sb [$];
  int n_assert;
  int n_fail;

  verificador_tabuleiro_if #(.MACRO_W(4), .CELL_W(2)) bus ();

  verificador_tabuleiro #(.MACRO_W(4), .CELL_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock)
    if (bus.le_ram) bus.dado <= mem[bus.addr_macro][bus.addr_celula];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] b, input logic [17:0] v);
    for (int i = 0; i < 9; i++) mem[b][i] = v[17-2*i -: 2];
  endtask

  function automatic exp_t modelo(input logic [3:0] b);
    int   ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    logic xl, ol, inv, full;
    exp_t e;
    xl = 0; ol = 0; inv = 0; full = 1;
    for (int k = 0; k < 9; k++) begin
      if (mem[b][k] == 2'b11) inv = 1;
      if (!(mem[b][k] == 2'b01 || mem[b][k] == 2'b10)) full = 0;
    end
    for (int l = 0; l < 8; l++) begin
      if (mem[b][ln[l][0]] == 2'b01 && mem[b][ln[l][1]] == 2'b01 &&
          mem[b][ln[l][2]] == 2'b01) xl = 1;
      if (mem[b][ln[l][0]] == 2'b10 && mem[b][ln[l][1]] == 2'b10 &&
          mem[b][ln[l][2]] == 2'b10) ol = 1;
    end
    e.vit = xl | ol;
    e.ven = xl ? 2'b01 : (ol ? 2'b10 : 2'b00);
    e.che = full;
    e.emp = full & ~(xl | ol);
    e.err = inv | (xl & ol);
    return e;
  endfunction

  task automatic scan(input logic [3:0] b, input int poke,
                      input int abort);
    exp_t e;
    int   cyc, lecnt, pc;
    logic got, ordok, amok;
    sb.push_back(modelo(b));
    @(negedge clock);
    bus.iniciar   = 1'b1;
    bus.tabuleiro = b;
    @(posedge clock);
    #1 bus.iniciar = 1'b0;
    cyc = 0; lecnt = 0; got = 0; ordok = 1; amok = 1;
    while (!got && cyc < 30) begin
      @(negedge clock);
      if (abort >= 0 && cyc == abort) begin
        reset = 1'b0;
        #1;
        chk("abort_estado", bus.db_estado, 0);
        chk("abort_ocupado", bus.ocupado, 0);
        chk("abort_le_ram", bus.le_ram, 0);
        chk("abort_addr_macro", bus.addr_macro, 0);
        chk("abort_addr_celula", bus.addr_celula, 0);
        chk("abort_vitoria", bus.vitoria, 0);
        chk("abort_vencedor", bus.vencedor, 0);
        void'(sb.pop_front());
        pc = 0;
        repeat (2) begin
          @(negedge clock);
          pc += bus.pronto;
        end
        reset = 1'b1;
        repeat (4) begin
          @(negedge clock);
          pc += bus.pronto;
        end
        chk("abort_no_pronto", pc, 0);
        return;
      end
      if (cyc == 0) chk("st_leitura", bus.db_estado, 1);
      if (cyc == 9) chk("st_espera", bus.db_estado, 2);
      if (cyc == 10) chk("st_avalia", bus.db_estado, 3);
      if (bus.pronto) begin
        got = 1;
        chk("latency", cyc, 11);
        chk("st_fim", bus.db_estado, 4);
        e = sb.pop_front();
        chk("vitoria", bus.vitoria, e.vit);
        chk("vencedor", bus.vencedor, e.ven);
        chk("empate", bus.empate, e.emp);
        chk("cheio", bus.cheio, e.che);
        chk("erro", bus.erro, e.err);
      end
      if (bus.le_ram) begin
        if (bus.addr_celula != lecnt[3:0]) ordok = 0;
        lecnt++;
      end
      if (bus.addr_macro != b) amok = 0;
      if (poke >= 0 && cyc == poke) begin
        bus.iniciar   = 1'b1;
        bus.tabuleiro = 4'd7;
      end else if (poke >= 0 && cyc == poke + 1) begin
        bus.iniciar   = 1'b0;
        bus.tabuleiro = b;
      end
      cyc++;
    end
    if (!got) begin
      chk("timeout_pronto", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    chk("le_ram_cycles", lecnt, 9);
    chk("addr_celula_order", ordok, 1);
    chk("addr_macro_held", amok, 1);
    pc = 0;
    repeat (4) begin
      @(negedge clock);
      pc += bus.pronto;
    end
    chk("pronto_single", pc, 0);
    chk("idle_ocupado", bus.ocupado, 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    for (int m = 0; m < 16; m++)
      for (int k = 0; k < 9; k++) mem[m][k] = 2'b00;
    bus.dado = 2'b00;
    bus.iniciar = 1'b0;
    bus.tabuleiro = 4'd0;
    reset = 1'b0;

    load(4'd3,  18'b01_01_01_00_00_00_00_00_00);
    load(4'd5,  18'b01_01_10_10_10_01_10_01_00);
    load(4'd0,  18'b01_10_01_01_10_10_10_01_01);
    load(4'd8,  18'b00_00_00_00_00_11_00_00_00);
    load(4'd9,  18'b01_01_01_00_00_00_10_10_10);
    load(4'd1,  18'b00_10_00_00_10_00_00_10_00);
    load(4'd7,  18'b01_01_01_01_01_01_01_01_01);
    load(4'd2,  18'b01_00_00_00_01_00_00_00_01);
    load(4'd12, 18'b01_01_01_01_01_01_01_01_01);

    repeat (3) @(negedge clock);
    chk("rst_estado", bus.db_estado, 0);
    chk("rst_ocupado", bus.ocupado, 0);
    chk("rst_pronto", bus.pronto, 0);
    chk("rst_le_ram", bus.le_ram, 0);
    chk("rst_addr_macro", bus.addr_macro, 0);
    chk("rst_addr_celula", bus.addr_celula, 0);
    chk("rst_results", {bus.vitoria, bus.vencedor, bus.empate,
                        bus.cheio, bus.erro}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    scan(4'd3, -1, -1);
    scan(4'd5, -1, -1);
    scan(4'd0, -1, -1);
    scan(4'd8, -1, -1);
    scan(4'd9, -1, -1);
    scan(4'd1, 3, -1);
    scan(4'd2, -1, 5);
    scan(4'd2, -1, -1);
    scan(4'd12, -1, -1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
